// File: rtl/fanout_fork_tracker_pkg.sv
// Shared types and helpers for the one-to-N stream fork.
// Optional stall counter in the top is enabled with FANOUT_PERF_EN.
package fanout_pkg;

    typedef enum logic {FORK_EAGER = 1'b0, FORK_LAZY = 1'b1} fork_mode_e;

    localparam int MAX_FANOUT = 32;
    localparam int MAX_SEL_W  = 32;

    // A branch participates only if it is enabled and its route select points at this fork.
    function automatic logic sel_active(input logic en, input logic [MAX_SEL_W-1:0] sel,
                                        input logic [4:0] sel_bit);
        return en & sel[sel_bit];
    endfunction

endpackage

// File: rtl/fanout_fork_tracker_if.sv
// Producer/consumer handshake bundle of the fork: slave is the fork, master is its environment.
interface fanout_fork_tracker_if #(
    parameter int NUM_OUT = 21,
    parameter int DATA_W  = 17
);
    logic                      in_valid;
    logic [DATA_W-1:0]         in_data;
    logic                      in_ready;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fanout_sat_counter.sv
// Saturating event counter with synchronous clear; used for fork stall statistics.
module fanout_sat_counter #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + PERF_W'(1);
        end
    end

endmodule

// File: rtl/fanout_fork_tracker.sv
// One-to-N broadcast fork with eager (per-branch taken bits) and lazy (all-ready) modes.
// Define FANOUT_PERF_EN to build the saturating stall counter; otherwise stall_cnt is tied to 0.
module fanout_fork_tracker
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = 21,
    parameter int DATA_W  = 17,
    parameter int SEL_W   = 8,
    parameter int SEL_BIT = 4,
    parameter int PERF_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  fork_mode_e               cfg_mode,
    input  logic [NUM_OUT-1:0]       cfg_en,
    input  logic [NUM_OUT*SEL_W-1:0] cfg_sel,
    fanout_fork_tracker_if.slave     bus,
    output logic [PERF_W-1:0]        stall_cnt
);

    logic [NUM_OUT-1:0] act;
    logic [NUM_OUT-1:0] taken;
    logic [NUM_OUT-1:0] can_go;
    logic [NUM_OUT-1:0] valid;
    logic               ready;
    logic               fire;

    always_comb begin
        act = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            act[i] = sel_active(cfg_en[i], MAX_SEL_W'(cfg_sel[i*SEL_W +: SEL_W]), 5'(SEL_BIT));
        end
    end

    // A branch stops blocking once it is inactive, already served, or ready now.
    always_comb begin
        can_go = '0;
        ready  = 1'b0;
        valid  = '0;
        if (cfg_mode == FORK_LAZY) begin
            can_go = ~act | bus.out_ready;
            ready  = &can_go;
            valid  = (bus.in_valid && ready) ? act : '0;
        end else begin
            can_go = ~act | taken | bus.out_ready;
            ready  = &can_go;
            valid  = bus.in_valid ? (act & ~taken) : '0;
        end
    end

    assign fire          = bus.in_valid & ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = {NUM_OUT{bus.in_data}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken <= '0;
        end else if (flush) begin
            taken <= '0;
        end else if ((cfg_mode == FORK_LAZY) || fire) begin
            taken <= '0;
        end else begin
            taken <= taken | (valid & bus.out_ready);
        end
    end

`ifdef FANOUT_PERF_EN
    fanout_sat_counter #(.PERF_W(PERF_W)) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.in_valid & ~ready),
        .clr   (flush),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule
